// File: rtl/bmc_pkg.sv
// Shared Viterbi front-end defaults and helpers for branch-metric sizing and label decoding.
package bmc_pkg;
  localparam int N_OUT_DEF  = 2;
  localparam int SOFT_W_DEF = 3;

  function automatic int bm_width(input int soft_w, input int n_out);
    return soft_w + $clog2(n_out + 1);
  endfunction

  function automatic logic label_bit(input int c, input int i);
    return ((c >> i) & 1) != 0;
  endfunction
endpackage

// File: rtl/bmc_soft_pipe_if.sv
// Symbol-in / metric-out streaming bus between the demapper and the ACS array.
interface bmc_soft_pipe_if import bmc_pkg::*; #(
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SOFT_W = SOFT_W_DEF
);
  localparam int L    = 1 << N_OUT;
  localparam int BM_W = bm_width(SOFT_W, N_OUT);

  logic                      in_valid;
  logic                      in_ready;
  logic [N_OUT*SOFT_W-1:0]   rx_sym;
  logic [N_OUT-1:0]          rx_erase;
  logic                      hard_mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [L*BM_W-1:0]         bm_out;

  modport master (
    output in_valid, rx_sym, rx_erase, hard_mode, out_ready,
    input  in_ready, out_valid, bm_out
  );
  modport slave (
    input  in_valid, rx_sym, rx_erase, hard_mode, out_ready,
    output in_ready, out_valid, bm_out
  );
endinterface

// File: rtl/bmc_min_norm.sv
// Optional normalisation stage: subtracts the smallest label metric so one label is always 0.
module bmc_min_norm #(
  parameter int L    = 4,
  parameter int BM_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [L-1:0][BM_W-1:0] bm_in,
  output logic [L-1:0][BM_W-1:0] bm_out
);
  logic [BM_W-1:0] mn;

  always_comb begin
    mn = bm_in[0];
    for (int c = 1; c < L; c++)
      if (bm_in[c] < mn) mn = bm_in[c];
  end

  always_ff @(posedge clk) begin
    if (rst)     bm_out <= '0;
    else if (en) for (int c = 0; c < L; c++) bm_out[c] <= bm_in[c] - mn;
  end
endmodule

// File: rtl/bmc_soft_pipe.sv
// Pipelined branch-metric unit: per-symbol distances (S1), per-label sums (S2), optional min-normalise (S3).
module bmc_soft_pipe import bmc_pkg::*; #(
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SOFT_W = SOFT_W_DEF,
  parameter bit NORM   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  bmc_soft_pipe_if.slave  bus
);
  localparam int L      = 1 << N_OUT;
  localparam int BM_W   = bm_width(SOFT_W, N_OUT);
  localparam int STAGES = NORM ? 3 : 2;
  localparam logic [SOFT_W-1:0] MAX = '1;

  logic [STAGES:1] vld_pipe, adv;
  logic [N_OUT-1:0][SOFT_W-1:0] d0_n, d1_n, d0_q, d1_q;
  logic [L-1:0][BM_W-1:0] bm_n, bm_q;

  // A stage may load once every stage from it to the output is either empty or draining.
  for (genvar k = 1; k <= STAGES; k++) begin : g_adv
    assign adv[k] = !(&vld_pipe[STAGES:k]) || bus.out_ready;
  end

  assign bus.in_ready  = adv[1];
  assign bus.out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else begin
      if (adv[1]) vld_pipe[1] <= bus.in_valid;
      for (int k = 2; k <= STAGES; k++)
        if (adv[k]) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_sym
    logic [SOFT_W-1:0] r;
    logic              era;
    assign r   = bus.rx_sym[i*SOFT_W +: SOFT_W];
    assign era = bus.rx_erase[i];
    assign d0_n[i] = era ? '0 : bus.hard_mode ? SOFT_W'(r[SOFT_W-1])  : r;
    assign d1_n[i] = era ? '0 : bus.hard_mode ? SOFT_W'(!r[SOFT_W-1]) : MAX - r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d0_q <= '0;
      d1_q <= '0;
    end else if (adv[1]) begin
      d0_q <= d0_n;
      d1_q <= d1_n;
    end
  end

  for (genvar c = 0; c < L; c++) begin : g_lbl
    logic [BM_W-1:0] acc;
    always_comb begin
      acc = '0;
      for (int i = 0; i < N_OUT; i++)
        acc = acc + BM_W'(label_bit(c, i) ? d1_q[i] : d0_q[i]);
    end
    assign bm_n[c] = acc;
  end

  always_ff @(posedge clk) begin
    if (rst)         bm_q <= '0;
    else if (adv[2]) bm_q <= bm_n;
  end

  if (NORM) begin : g_norm
    logic [L-1:0][BM_W-1:0] bm_nrm;
    bmc_min_norm #(.L(L), .BM_W(BM_W)) u_norm (
      .clk    (clk),
      .rst    (rst),
      .en     (adv[STAGES]),
      .bm_in  (bm_q),
      .bm_out (bm_nrm)
    );
    assign bus.bm_out = bm_nrm;
  end else begin : g_raw
    assign bus.bm_out = bm_q;
  end
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Bench for bmc_soft_pipe: directed vector table on NORM=0/1 instances, stall/reset sequences, random stream vs model.
module tb_bmc_soft_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bmc_soft_pipe_if #(.N_OUT(2), .SOFT_W(3)) if0 ();
  bmc_soft_pipe_if #(.N_OUT(2), .SOFT_W(3)) if1 ();

  bmc_soft_pipe #(.N_OUT(2), .SOFT_W(3), .NORM(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  bmc_soft_pipe #(.N_OUT(2), .SOFT_W(3), .NORM(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // Metrics straight from the distance rules, 5-bit fields, label c at [c*5 +: 5].
  function automatic logic [19:0] ref_bm(input logic [5:0] s, input logic [1:0] e, input bit hard, input bit norm);
    int m[4];
    int mn;
    logic [19:0] o;
    for (int c = 0; c < 4; c++) begin
      m[c] = 0;
      for (int i = 0; i < 2; i++) begin
        int r;
        int b;
        int h;
        r = (int'(s) >> (3 * i)) & 7;
        b = (c >> i) & 1;
        h = (r >= 4) ? 1 : 0;
        if (!e[i]) begin
          if (hard) m[c] += (b == 1) ? 1 - h : h;
          else      m[c] += (b == 1) ? 7 - r : r;
        end
      end
    end
    mn = m[0];
    for (int c = 1; c < 4; c++) if (m[c] < mn) mn = m[c];
    o = '0;
    for (int c = 0; c < 4; c++) o[c*5 +: 5] = 5'(norm ? m[c] - mn : m[c]);
    return o;
  endfunction

  typedef struct {
    bit          norm;
    logic [2:0]  r0, r1;
    logic [1:0]  er;
    bit          hard;
    int          lat;
    logic [19:0] exp;
  } vec_t;

  vec_t vt[10];

  logic [19:0] expq[$];
  bit          prev_hold = 1'b0;
  logic [19:0] prev_bm;
  int          n_emit = 0;

  task automatic run_vec(input int idx, input vec_t t);
    int lat;
    logic ov;
    logic [19:0] bm;
    @(negedge clk);
    if (t.norm) begin
      if1.in_valid = 1'b1; if1.rx_sym = {t.r1, t.r0}; if1.rx_erase = t.er; if1.hard_mode = t.hard;
    end else begin
      if0.in_valid = 1'b1; if0.rx_sym = {t.r1, t.r0}; if0.rx_erase = t.er; if0.hard_mode = t.hard;
    end
    @(negedge clk);
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    lat = 1;
    ov  = t.norm ? if1.out_valid : if0.out_valid;
    while (!ov && lat < 8) begin
      @(negedge clk);
      lat++;
      ov = t.norm ? if1.out_valid : if0.out_valid;
    end
    bm = t.norm ? if1.bm_out : if0.bm_out;
    chk(lat == t.lat, $sformatf("vec%0d_latency", idx), lat, t.lat);
    chk(bm == t.exp, $sformatf("vec%0d_bm", idx), bm, t.exp);
    @(negedge clk);
  endtask

  // One streaming cycle on the NORM=0 instance; inputs settle, then handshakes are scored.
  task automatic cycle(input bit v, input logic [5:0] s, input logic [1:0] e, input bit h,
                       input bit ordy, output bit acc);
    logic [19:0] ex;
    @(negedge clk);
    if0.in_valid = v; if0.rx_sym = s; if0.rx_erase = e; if0.hard_mode = h; if0.out_ready = ordy;
    #1;
    if (prev_hold)
      chk(if0.out_valid && if0.bm_out == prev_bm, "hold_stable", if0.bm_out, prev_bm);
    acc = v && if0.in_ready && !rst;
    if (acc) expq.push_back(ref_bm(s, e, h, 1'b0));
    if (if0.out_valid && ordy && !rst) begin
      n_emit++;
      if (expq.size() == 0) chk(1'b0, "unexpected_beat", if0.bm_out, 0);
      else begin
        ex = expq.pop_front();
        chk(if0.bm_out == ex, "stream_bm", if0.bm_out, ex);
      end
    end
    prev_hold = if0.out_valid && !ordy && !rst;
    prev_bm   = if0.bm_out;
  endtask

  initial begin
    bit acc;
    int idx;
    int e0;
    logic [5:0] bs[4];

    vt[0] = '{1'b0, 3'd7, 3'd0, 2'b00, 1'b0, 2, {5'd7,  5'd14, 5'd0,  5'd7}};
    vt[1] = '{1'b0, 3'd5, 3'd2, 2'b00, 1'b1, 2, {5'd1,  5'd2,  5'd0,  5'd1}};
    vt[2] = '{1'b0, 3'd5, 3'd2, 2'b00, 1'b0, 2, {5'd7,  5'd10, 5'd4,  5'd7}};
    vt[3] = '{1'b0, 3'd0, 3'd6, 2'b10, 1'b0, 2, {5'd7,  5'd0,  5'd7,  5'd0}};
    vt[4] = '{1'b0, 3'd3, 3'd3, 2'b11, 1'b0, 2, {5'd0,  5'd0,  5'd0,  5'd0}};
    vt[5] = '{1'b0, 3'd7, 3'd7, 2'b01, 1'b1, 2, {5'd0,  5'd0,  5'd1,  5'd1}};
    vt[6] = '{1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 2, {5'd14, 5'd7,  5'd7,  5'd0}};
    vt[7] = '{1'b1, 3'd3, 3'd4, 2'b00, 1'b0, 3, {5'd1,  5'd0,  5'd2,  5'd1}};
    vt[8] = '{1'b1, 3'd7, 3'd7, 2'b00, 1'b0, 3, {5'd0,  5'd7,  5'd7,  5'd14}};
    vt[9] = '{1'b1, 3'd0, 3'd7, 2'b00, 1'b1, 3, {5'd1,  5'd0,  5'd2,  5'd1}};

    rst = 1'b1;
    if0.in_valid = 1'b1; if0.rx_sym = 6'o70; if0.rx_erase = '0; if0.hard_mode = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b1; if1.rx_sym = 6'o70; if1.rx_erase = '0; if1.hard_mode = 1'b0; if1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk(!if0.out_valid, "rst_out_valid0", if0.out_valid, 0);
    chk(if0.bm_out == '0, "rst_bm0", if0.bm_out, 0);
    chk(!if1.out_valid, "rst_out_valid1", if1.out_valid, 0);
    chk(if1.bm_out == '0, "rst_bm1", if1.bm_out, 0);
    rst = 1'b0;
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    #1;
    chk(if0.in_ready, "rst_in_ready0", if0.in_ready, 1);
    chk(if1.in_ready, "rst_in_ready1", if1.in_ready, 1);

    for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

    // Hard then soft on consecutive beats with identical symbols.
    cycle(1'b1, {3'd2, 3'd5}, 2'b00, 1'b1, 1'b1, acc);
    chk(acc, "mode_sw_acc0", acc, 1);
    cycle(1'b1, {3'd2, 3'd5}, 2'b00, 1'b0, 1'b1, acc);
    chk(acc, "mode_sw_acc1", acc, 1);
    e0 = n_emit;
    repeat (4) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk(n_emit - e0 == 2, "mode_sw_emits", n_emit - e0, 2);

    // Six stalled cycles while four distinct beats are offered.
    bs[0] = {3'd1, 3'd6}; bs[1] = {3'd4, 3'd2}; bs[2] = {3'd7, 3'd3}; bs[3] = {3'd0, 3'd5};
    idx = 0;
    e0  = n_emit;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, bs[idx], 2'b00, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk(idx == 2, "bp_accepted", idx, 2);
    chk(!if0.in_ready, "bp_in_ready", if0.in_ready, 0);
    chk(if0.out_valid, "bp_out_valid", if0.out_valid, 1);
    for (int c = 0; c < 20 && (idx < 4 || expq.size() != 0); c++) begin
      cycle(idx < 4, bs[idx & 3], 2'b00, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk(idx == 4 && expq.size() == 0, "bp_drain", expq.size(), 0);
    chk(n_emit - e0 == 4, "bp_emits", n_emit - e0, 4);

    // Reset in the middle of a stall drops everything in flight.
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, bs[idx], 2'b01, 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    chk(idx == 2, "rst_stall_acc", idx, 2);
    @(negedge clk);
    rst = 1'b1;
    if0.in_valid = 1'b1; if0.rx_sym = bs[3];
    @(negedge clk);
    rst = 1'b0;
    if0.in_valid = 1'b0;
    expq.delete();
    prev_hold = 1'b0;
    #1;
    chk(!if0.out_valid, "rst_mid_out_valid", if0.out_valid, 0);
    chk(if0.in_ready, "rst_mid_in_ready", if0.in_ready, 1);
    chk(if0.bm_out == '0, "rst_mid_bm", if0.bm_out, 0);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk(!if0.out_valid, "stale_beat", if0.out_valid, 0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++)
      cycle($urandom_range(0, 9) < 7, 6'($urandom), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
            1'($urandom), $urandom_range(0, 9) < 6, acc);
    for (int c = 0; c < 50 && expq.size() != 0; c++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk(expq.size() == 0, "random_drain", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
